// File: rtl/mem_wb_pipe_pkg.sv
// rtl/mem_wb_pipe_pkg.sv - shared defaults and constants for the MEM/WB pipeline
package mem_wb_pipe_pkg;
  localparam int unsigned DEF_BUS_SIZE      = 32;
  localparam int unsigned DEF_MEM_ADDR_SIZE = 5;
  localparam int unsigned DEF_STAGES        = 1;
  localparam int unsigned DEF_CNT_SIZE      = 32;
  localparam int unsigned REG_ZERO          = 0;
endpackage

// File: rtl/mem_wb_pipe_wb_stage_reg.sv
// rtl/mem_wb_pipe_wb_stage_reg.sv - one MEM/WB stage with sync reset, flush, enable and pass-through
import mem_wb_pipe_pkg::*;

module wb_stage_reg #(
  parameter int unsigned BUS_SIZE  = DEF_BUS_SIZE,
  parameter int unsigned ADDR_SIZE = DEF_MEM_ADDR_SIZE
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_flush,
  input  logic                 i_enable,
  input  logic                 i_valid,
  input  logic                 i_wb,
  input  logic                 i_mem_to_reg,
  input  logic [BUS_SIZE-1:0]  i_mem_result,
  input  logic [BUS_SIZE-1:0]  i_alu_result,
  input  logic [ADDR_SIZE-1:0] i_addr_wr,
  input  logic [BUS_SIZE-1:0]  i_wb_data,
  output logic                 o_valid,
  output logic                 o_wb,
  output logic                 o_mem_to_reg,
  output logic [BUS_SIZE-1:0]  o_mem_result,
  output logic [BUS_SIZE-1:0]  o_alu_result,
  output logic [ADDR_SIZE-1:0] o_addr_wr,
  output logic [BUS_SIZE-1:0]  o_wb_data
);
  logic                 valid_q, valid_d;
  logic                 wb_q, wb_d;
  logic                 mem_to_reg_q, mem_to_reg_d;
  logic [BUS_SIZE-1:0]  mem_result_q, mem_result_d;
  logic [BUS_SIZE-1:0]  alu_result_q, alu_result_d;
  logic [ADDR_SIZE-1:0] addr_wr_q, addr_wr_d;
  logic [BUS_SIZE-1:0]  wb_data_q, wb_data_d;

  // Flush outranks enable so a flushed edge never captures the incoming instruction.
  always_comb begin
    valid_d      = valid_q;
    wb_d         = wb_q;
    mem_to_reg_d = mem_to_reg_q;
    mem_result_d = mem_result_q;
    alu_result_d = alu_result_q;
    addr_wr_d    = addr_wr_q;
    wb_data_d    = wb_data_q;
    if (i_flush) begin
      valid_d      = 1'b0;
      wb_d         = 1'b0;
      mem_to_reg_d = 1'b0;
      mem_result_d = '0;
      alu_result_d = '0;
      addr_wr_d    = '0;
      wb_data_d    = '0;
    end else if (i_enable) begin
      valid_d      = i_valid;
      wb_d         = i_wb;
      mem_to_reg_d = i_mem_to_reg;
      mem_result_d = i_mem_result;
      alu_result_d = i_alu_result;
      addr_wr_d    = i_addr_wr;
      wb_data_d    = i_wb_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      valid_q      <= 1'b0;
      wb_q         <= 1'b0;
      mem_to_reg_q <= 1'b0;
      mem_result_q <= '0;
      alu_result_q <= '0;
      addr_wr_q    <= '0;
      wb_data_q    <= '0;
    end else begin
      valid_q      <= valid_d;
      wb_q         <= wb_d;
      mem_to_reg_q <= mem_to_reg_d;
      mem_result_q <= mem_result_d;
      alu_result_q <= alu_result_d;
      addr_wr_q    <= addr_wr_d;
      wb_data_q    <= wb_data_d;
    end
  end

  assign o_valid      = valid_q;
  assign o_wb         = wb_q;
  assign o_mem_to_reg = mem_to_reg_q;
  assign o_mem_result = mem_result_q;
  assign o_alu_result = alu_result_q;
  assign o_addr_wr    = addr_wr_q;
  assign o_wb_data    = wb_data_q;
endmodule

// File: rtl/mem_wb_pipe.sv
// rtl/mem_wb_pipe.sv - multi-stage MEM/WB register chain with forwarding lookup and retire counter
import mem_wb_pipe_pkg::*;

module mem_wb_pipe #(
  parameter int unsigned BUS_SIZE      = DEF_BUS_SIZE,
  parameter int unsigned MEM_ADDR_SIZE = DEF_MEM_ADDR_SIZE,
  parameter int unsigned STAGES        = DEF_STAGES,
  parameter int unsigned CNT_SIZE      = DEF_CNT_SIZE
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_enable,
  input  logic                     i_flush,
  input  logic                     i_valid,
  input  logic                     i_wb,
  input  logic                     i_mem_to_reg,
  input  logic [BUS_SIZE-1:0]      i_mem_result,
  input  logic [BUS_SIZE-1:0]      i_alu_result,
  input  logic [MEM_ADDR_SIZE-1:0] i_addr_wr,
  input  logic [MEM_ADDR_SIZE-1:0] i_rs_addr,
  input  logic [MEM_ADDR_SIZE-1:0] i_rt_addr,
  output logic                     o_wb,
  output logic [MEM_ADDR_SIZE-1:0] o_addr_wr,
  output logic [BUS_SIZE-1:0]      o_wb_data,
  output logic [BUS_SIZE-1:0]      o_mem_result,
  output logic [BUS_SIZE-1:0]      o_alu_result,
  output logic                     o_mem_to_reg,
  output logic                     o_fwd_rs_hit,
  output logic                     o_fwd_rt_hit,
  output logic [BUS_SIZE-1:0]      o_fwd_rs_data,
  output logic [BUS_SIZE-1:0]      o_fwd_rt_data,
  output logic [CNT_SIZE-1:0]      o_retired
);
  localparam int unsigned LAST = STAGES - 1;
  localparam logic [MEM_ADDR_SIZE-1:0] ZERO_ADDR = MEM_ADDR_SIZE'(REG_ZERO);

  logic                     st_valid [STAGES];
  logic                     st_wb    [STAGES];
  logic                     st_mtr   [STAGES];
  logic [BUS_SIZE-1:0]      st_mem   [STAGES];
  logic [BUS_SIZE-1:0]      st_alu   [STAGES];
  logic [MEM_ADDR_SIZE-1:0] st_addr  [STAGES];
  logic [BUS_SIZE-1:0]      st_wbd   [STAGES];

  logic [BUS_SIZE-1:0] in_wb_data;
  assign in_wb_data = i_mem_to_reg ? i_mem_result : i_alu_result;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic                     v_in, w_in, m_in;
    logic [BUS_SIZE-1:0]      mem_in, alu_in, wbd_in;
    logic [MEM_ADDR_SIZE-1:0] addr_in;

    if (k == 0) begin : g_head
      assign v_in    = i_valid;
      assign w_in    = i_wb;
      assign m_in    = i_mem_to_reg;
      assign mem_in  = i_mem_result;
      assign alu_in  = i_alu_result;
      assign addr_in = i_addr_wr;
      assign wbd_in  = in_wb_data;
    end else begin : g_tail
      assign v_in    = st_valid[k-1];
      assign w_in    = st_wb[k-1];
      assign m_in    = st_mtr[k-1];
      assign mem_in  = st_mem[k-1];
      assign alu_in  = st_alu[k-1];
      assign addr_in = st_addr[k-1];
      assign wbd_in  = st_wbd[k-1];
    end

    wb_stage_reg #(
      .BUS_SIZE  (BUS_SIZE),
      .ADDR_SIZE (MEM_ADDR_SIZE)
    ) u_stage (
      .i_clk        (i_clk),
      .i_reset      (i_reset),
      .i_flush      (i_flush),
      .i_enable     (i_enable),
      .i_valid      (v_in),
      .i_wb         (w_in),
      .i_mem_to_reg (m_in),
      .i_mem_result (mem_in),
      .i_alu_result (alu_in),
      .i_addr_wr    (addr_in),
      .i_wb_data    (wbd_in),
      .o_valid      (st_valid[k]),
      .o_wb         (st_wb[k]),
      .o_mem_to_reg (st_mtr[k]),
      .o_mem_result (st_mem[k]),
      .o_alu_result (st_alu[k]),
      .o_addr_wr    (st_addr[k]),
      .o_wb_data    (st_wbd[k])
    );
  end

  // Scan oldest to youngest so the youngest matching stage overwrites and wins.
  always_comb begin
    o_fwd_rs_hit  = 1'b0;
    o_fwd_rs_data = '0;
    o_fwd_rt_hit  = 1'b0;
    o_fwd_rt_data = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      if (st_valid[k] && st_wb[k]) begin
        if (i_rs_addr != ZERO_ADDR && st_addr[k] == i_rs_addr) begin
          o_fwd_rs_hit  = 1'b1;
          o_fwd_rs_data = st_wbd[k];
        end
        if (i_rt_addr != ZERO_ADDR && st_addr[k] == i_rt_addr) begin
          o_fwd_rt_hit  = 1'b1;
          o_fwd_rt_data = st_wbd[k];
        end
      end
    end
  end

  logic [CNT_SIZE-1:0] retired_q, retired_d;

  always_comb begin
    retired_d = retired_q;
    if (i_enable && !i_flush && st_valid[LAST] && st_wb[LAST])
      retired_d = retired_q + CNT_SIZE'(1);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) retired_q <= '0;
    else         retired_q <= retired_d;
  end

  assign o_wb         = st_valid[LAST] && st_wb[LAST];
  assign o_addr_wr    = st_addr[LAST];
  assign o_wb_data    = st_wbd[LAST];
  assign o_mem_result = st_mem[LAST];
  assign o_alu_result = st_alu[LAST];
  assign o_mem_to_reg = st_mtr[LAST];
  assign o_retired    = retired_q;
endmodule

// File: tb/tb_mem_wb_pipe.sv
// tb/tb_mem_wb_pipe.sv - directed self-checking bench for mem_wb_pipe (3 stages, 4-bit counter)
module tb_mem_wb_pipe;
  logic        clk = 1'b0;
  logic        i_reset, i_enable, i_flush, i_valid, i_wb, i_mem_to_reg;
  logic [31:0] i_mem_result, i_alu_result;
  logic [4:0]  i_addr_wr, i_rs_addr, i_rt_addr;
  logic        o_wb, o_mem_to_reg, o_fwd_rs_hit, o_fwd_rt_hit;
  logic [4:0]  o_addr_wr;
  logic [31:0] o_wb_data, o_mem_result, o_alu_result, o_fwd_rs_data, o_fwd_rt_data;
  logic [3:0]  o_retired;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
  } exp_t;
  exp_t sb[$];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_wb_pipe #(
    .BUS_SIZE(32), .MEM_ADDR_SIZE(5), .STAGES(3), .CNT_SIZE(4)
  ) dut (
    .i_clk(clk), .i_reset(i_reset), .i_enable(i_enable), .i_flush(i_flush),
    .i_valid(i_valid), .i_wb(i_wb), .i_mem_to_reg(i_mem_to_reg),
    .i_mem_result(i_mem_result), .i_alu_result(i_alu_result),
    .i_addr_wr(i_addr_wr), .i_rs_addr(i_rs_addr), .i_rt_addr(i_rt_addr),
    .o_wb(o_wb), .o_addr_wr(o_addr_wr), .o_wb_data(o_wb_data),
    .o_mem_result(o_mem_result), .o_alu_result(o_alu_result),
    .o_mem_to_reg(o_mem_to_reg), .o_fwd_rs_hit(o_fwd_rs_hit),
    .o_fwd_rt_hit(o_fwd_rt_hit), .o_fwd_rs_data(o_fwd_rs_data),
    .o_fwd_rt_data(o_fwd_rt_data), .o_retired(o_retired)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic w, input logic m,
                       input logic [31:0] mem, input logic [31:0] alu, input logic [4:0] a);
    exp_t e;
    i_valid = v; i_wb = w; i_mem_to_reg = m;
    i_mem_result = mem; i_alu_result = alu; i_addr_wr = a;
    if (v && w && i_enable && !i_flush && !i_reset) begin
      e.addr = a;
      e.data = m ? mem : alu;
      sb.push_back(e);
    end
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
  endtask

  // One clock; when the edge advanced the chain and a writeback emerged, pop and compare it.
  task automatic cycle();
    logic adv;
    exp_t e;
    adv = i_enable && !i_flush && !i_reset;
    @(posedge clk);
    @(negedge clk);
    if (adv && o_wb === 1'b1) begin
      if (sb.size() == 0) chk("sb_unexpected_wb", o_wb, 64'd0);
      else begin
        e = sb.pop_front();
        chk("sb_addr", o_addr_wr, e.addr);
        chk("sb_data", o_wb_data, e.data);
      end
    end
  endtask

  initial begin
    i_reset = 1'b1; i_enable = 1'b1; i_flush = 1'b0;
    i_rs_addr = 5'd0; i_rt_addr = 5'd0;
    idle();
    cycle(); cycle();
    i_reset = 1'b0;
    cycle();
    chk("rst_o_wb", o_wb, 0);
    chk("rst_addr", o_addr_wr, 0);
    chk("rst_wb_data", o_wb_data, 0);
    chk("rst_mem", o_mem_result, 0);
    chk("rst_alu", o_alu_result, 0);
    chk("rst_mtr", o_mem_to_reg, 0);
    chk("rst_rs_hit", o_fwd_rs_hit, 0);
    chk("rst_rt_hit", o_fwd_rt_hit, 0);
    chk("rst_retired", o_retired, 0);

    // basic pass through three stages
    drive(1'b1, 1'b1, 1'b1, 32'hDEAD0001, 32'h5, 5'd7);
    cycle(); idle();
    chk("basic_wb_e1", o_wb, 0);
    cycle();
    chk("basic_wb_e2", o_wb, 0);
    cycle();
    chk("basic_wb_e3", o_wb, 1);
    chk("basic_data_e3", o_wb_data, 32'hDEAD0001);
    chk("basic_addr_e3", o_addr_wr, 7);
    chk("basic_alu_e3", o_alu_result, 32'h5);
    chk("basic_mtr_e3", o_mem_to_reg, 1);
    chk("basic_ret_e3", o_retired, 0);
    cycle();
    chk("basic_ret_e4", o_retired, 1);
    chk("basic_wb_e4", o_wb, 0);

    // stall mid-chain, ALU writeback source
    drive(1'b1, 1'b1, 1'b0, 32'hFFFF, 32'h1234ABCD, 5'd9);
    cycle(); idle();
    i_enable = 1'b0;
    cycle(); cycle();
    chk("stall_wb", o_wb, 0);
    chk("stall_ret", o_retired, 1);
    i_enable = 1'b1;
    cycle();
    chk("stall_wb_e2", o_wb, 0);
    cycle();
    chk("stall_wb_e3", o_wb, 1);
    chk("stall_data", o_wb_data, 32'h1234ABCD);
    chk("stall_mtr", o_mem_to_reg, 0);
    i_enable = 1'b0;
    cycle();
    chk("stall_last_wb", o_wb, 1);
    chk("stall_last_ret", o_retired, 1);
    i_enable = 1'b1;
    cycle();
    chk("stall_ret_after", o_retired, 2);

    // flush with enable
    drive(1'b1, 1'b1, 1'b0, 32'h0, 32'hC1, 5'd1); cycle();
    drive(1'b1, 1'b1, 1'b0, 32'h0, 32'hC2, 5'd2); cycle();
    drive(1'b1, 1'b1, 1'b0, 32'h0, 32'hC3, 5'd3); cycle();
    chk("flush_pre_wb", o_wb, 1);
    i_flush = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 32'h0, 32'hC4, 5'd4);
    cycle();
    i_flush = 1'b0;
    idle();
    sb.delete();
    chk("flush_wb", o_wb, 0);
    chk("flush_ret", o_retired, 2);
    i_rs_addr = 5'd4; i_rt_addr = 5'd2;
    #1;
    chk("flush_rs_hit", o_fwd_rs_hit, 0);
    chk("flush_rt_hit", o_fwd_rt_hit, 0);
    cycle(); cycle(); cycle();
    chk("flush_drain_wb", o_wb, 0);
    chk("flush_drain_ret", o_retired, 2);

    // forwarding priority and register zero
    drive(1'b1, 1'b1, 1'b0, 32'h0, 32'h22, 5'd5); cycle();
    drive(1'b1, 1'b1, 1'b0, 32'h0, 32'h99, 5'd0); cycle();
    drive(1'b1, 1'b1, 1'b0, 32'h0, 32'h11, 5'd5); cycle();
    i_rs_addr = 5'd5; i_rt_addr = 5'd0;
    #1;
    chk("fwd_rs_hit", o_fwd_rs_hit, 1);
    chk("fwd_rs_data", o_fwd_rs_data, 32'h11);
    chk("fwd_r0_hit", o_fwd_rt_hit, 0);
    chk("fwd_r0_data", o_fwd_rt_data, 0);
    i_rt_addr = 5'd7;
    #1;
    chk("fwd_miss_hit", o_fwd_rt_hit, 0);

    // bubble with wb set
    drive(1'b0, 1'b1, 1'b0, 32'h0, 32'h66, 5'd6); cycle();
    idle();
    chk("bub_ret_d1", o_retired, 3);
    i_rs_addr = 5'd6;
    #1;
    chk("bub_rs_hit", o_fwd_rs_hit, 0);
    cycle(); cycle();
    chk("bub_wb", o_wb, 0);
    cycle();
    chk("bub_ret", o_retired, 5);

    // reset while stalled
    drive(1'b1, 1'b1, 1'b1, 32'hE0E0, 32'h0, 5'd3);
    cycle(); idle(); cycle(); cycle();
    chk("rstall_pre_wb", o_wb, 1);
    i_enable = 1'b0; i_reset = 1'b1;
    cycle();
    i_reset = 1'b0; i_enable = 1'b1;
    chk("rstall_wb", o_wb, 0);
    chk("rstall_addr", o_addr_wr, 0);
    chk("rstall_data", o_wb_data, 0);
    chk("rstall_ret", o_retired, 0);
    sb.delete();

    // 16 retirements wrap the 4-bit counter
    for (int i = 0; i < 19; i++) begin
      if (i < 16) drive(1'b1, 1'b1, i[0], 32'h01010101 * i, 32'hA0000000 + i, 5'(i + 1));
      else idle();
      cycle();
      if (i == 17) chk("wrap_ret_15", o_retired, 15);
      if (i == 18) chk("wrap_ret_0", o_retired, 0);
    end
    chk("wrap_sb_empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
